// File: rtl/irq_pending_ctrl.sv
// Interrupt pending/mask controller feeding CP0 HWInt[7:2].
// Latches edge or level sources, masks them, and exposes a 16-byte PEND/MASK/ID/EOI window.
module irq_pending_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F30,
  parameter logic [5:0]  EDGE_SRC  = 6'b000111
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  src,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [5:0]  hwint,
  output logic        irq_any
);

  typedef enum logic [1:0] {
    REG_PEND = 2'd0,
    REG_MASK = 2'd1,
    REG_ID   = 2'd2,
    REG_EOI  = 2'd3
  } reg_sel_e;

  logic [5:0] pend;
  logic [5:0] mask;
  logic [5:0] src_q;
  logic [5:0] active;
  logic [5:0] set_vec;
  logic [5:0] clr_vec;
  logic [5:0] pend_next;
  logic [5:0] id_onehot;
  logic [2:0] id_idx;
  logic       id_valid;
  logic       hit;
  logic       wr_pend;
  logic       wr_mask;
  logic       wr_eoi;
  reg_sel_e   sel;

  // Byte lanes and upper write-data bits carry no meaning in this window.
  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wdata[31:6]};

  assign hit    = (addr[31:4] == BASE_ADDR[31:4]);
  assign sel    = reg_sel_e'(addr[3:2]);
  assign active = pend & mask;

  assign wr_pend = we && hit && (sel == REG_PEND);
  assign wr_mask = we && hit && (sel == REG_MASK);
  assign wr_eoi  = we && hit && (sel == REG_EOI);

  // Lowest active index wins; scanning downward leaves the lowest hit last.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    id_valid  = 1'b0;
    id_idx    = 3'd0;
    id_onehot = 6'd0;
    for (int i = 5; i >= 0; i--) begin
      if (active[i]) begin
        id_valid  = 1'b1;
        id_idx    = 3'(i);
        id_onehot = 6'd1 << i;
      end
    end
  end

  assign set_vec   = (EDGE_SRC & src & ~src_q) | (~EDGE_SRC & src);
  assign clr_vec   = (wr_pend ? wdata[5:0] : 6'd0) | (wr_eoi ? id_onehot : 6'd0);
  // Set is OR-ed in after the clear so a same-cycle set always survives.
  assign pend_next = (pend & ~clr_vec) | set_vec;

  always_comb begin
    rdata = 32'd0;
    if (hit) begin
      unique case (sel)
        REG_PEND: rdata = {26'd0, pend};
        REG_MASK: rdata = {26'd0, mask};
        REG_ID:   rdata = id_valid ? {1'b1, 28'd0, id_idx} : 32'd0;
        REG_EOI:  rdata = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values together.
    if (reset) begin
      pend    <= 6'd0;
      mask    <= 6'd0;
      src_q   <= 6'd0;
      hwint   <= 6'd0;
      irq_any <= 1'b0;
    end else begin
      src_q   <= src;
      pend    <= pend_next;
      hwint   <= active;
      irq_any <= |active;
      if (wr_mask) mask <= wdata[5:0];
    end
  end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Self-checking bench for irq_pending_ctrl: directed scenarios plus random traffic
// compared every cycle against a behavioural model of the controller.
module tb_irq_pending_ctrl;

  localparam logic [31:0] BASE = 32'h0000_7F30;
  localparam logic [5:0]  EDGE = 6'b000111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  src = 6'd0;
  logic [31:0] addr = 32'd0;
  logic        we = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic [5:0]  hwint;
  logic        irq_any;

  int vectors = 0;
  int miscompares = 0;
  bit armed = 1'b0;

  // Model state: plain per-source flags.
  bit m_pend [6];
  bit m_mask [6];
  bit m_prev [6];
  bit m_hw   [6];
  bit m_any;

  irq_pending_ctrl #(.BASE_ADDR(BASE), .EDGE_SRC(EDGE)) dut (
    .clk(clk), .reset(reset), .src(src), .addr(addr), .we(we),
    .wdata(wdata), .rdata(rdata), .hwint(hwint), .irq_any(irq_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_id();
    for (int i = 0; i < 6; i++)
      if (m_pend[i] && m_mask[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] pack(input bit v [6]);
    logic [31:0] r = 32'd0;
    for (int i = 0; i < 6; i++) r[i] = v[i];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int id;
    if (a[31:4] != BASE[31:4]) return 32'd0;
    case (a[3:2])
      2'd0: return pack(m_pend);
      2'd1: return pack(m_mask);
      2'd2: begin
        id = m_id();
        return (id < 0) ? 32'd0 : (32'h8000_0000 + id);
      end
      default: return 32'd0;
    endcase
  endfunction

  // Reference model advanced on each rising edge from the inputs as sampled there.
  always @(posedge clk) begin
    int  id;
    bit  clr [6];
    bit  inw;
    if (reset) begin
      for (int i = 0; i < 6; i++) begin
        m_pend[i] = 0; m_mask[i] = 0; m_prev[i] = 0; m_hw[i] = 0;
      end
      m_any = 0;
      armed = 1'b1;
    end else begin
      id  = m_id();
      inw = (addr[31:4] == BASE[31:4]);
      m_any = 0;
      for (int i = 0; i < 6; i++) begin
        clr[i]  = 0;
        m_hw[i] = m_pend[i] && m_mask[i];
        if (m_hw[i]) m_any = 1;
      end
      if (we && inw) begin
        case (addr[3:2])
          2'd0: for (int i = 0; i < 6; i++) clr[i] = wdata[i];
          2'd1: for (int i = 0; i < 6; i++) m_mask[i] = wdata[i];
          2'd3: if (id >= 0) clr[id] = 1;
          default: ;
        endcase
      end
      for (int i = 0; i < 6; i++) begin
        if (clr[i]) m_pend[i] = 0;
        if (EDGE[i] ? (src[i] && !m_prev[i]) : src[i]) m_pend[i] = 1;
        m_prev[i] = src[i];
      end
    end
  end

  // Single compare process: outputs are stable mid-cycle.
  always @(negedge clk) begin
    if (armed) begin
      check("hwint", {26'd0, hwint}, pack(m_hw));
      check("irq_any", {31'd0, irq_any}, {31'd0, m_any});
      check("rdata", rdata, m_read(addr));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    addr = BASE + off; wdata = d; we = 1'b1;
    tick(1);
    we = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [31:0] off, input logic [31:0] exp);
    addr = BASE + off;
    #1;
    check(name, rdata, exp);
  endtask

  initial begin
    // Reset state
    reset = 1'b1; src = 6'd0;
    tick(2);
    reset = 1'b0;
    check("reset_hwint", {26'd0, hwint}, 32'd0);
    check("reset_irq", {31'd0, irq_any}, 32'd0);
    rd_check("reset_pend", 32'h0, 32'd0);
    rd_check("reset_mask", 32'h4, 32'd0);

    // Edge latch and priority
    wr(32'h4, 32'h3F);
    src = 6'h08; tick(1);
    src = 6'h00; tick(1);
    src = 6'h02; tick(1);
    src = 6'h00; tick(1);
    check("prio_hwint", {26'd0, hwint}, 32'b001010);
    check("prio_irq", {31'd0, irq_any}, 32'd1);
    rd_check("prio_id", 32'h8, 32'h8000_0001);
    wr(32'hC, 32'h0);
    rd_check("eoi_id", 32'h8, 32'h8000_0003);
    rd_check("eoi_pend", 32'h0, 32'h08);
    wr(32'h0, 32'h3F);
    tick(1);

    // Masking
    wr(32'h4, 32'h0);
    src = 6'h01; tick(1);
    src = 6'h00; tick(2);
    rd_check("mask_pend", 32'h0, 32'h01);
    check("mask_hwint", {26'd0, hwint}, 32'd0);
    rd_check("mask_id", 32'h8, 32'd0);
    wr(32'h4, 32'h1);
    rd_check("mask_readback", 32'h4, 32'h01);
    tick(1);
    check("unmask_hwint", {26'd0, hwint}, 32'b000001);
    wr(32'h0, 32'h1);
    wr(32'h4, 32'h3F);
    tick(1);

    // Level source
    src = 6'h10; tick(1);
    wr(32'h0, 32'h10);
    rd_check("level_held", 32'h0, 32'h10);
    src = 6'h00; tick(1);
    wr(32'h0, 32'h10);
    rd_check("level_clr", 32'h0, 32'h00);
    check("level_hw_still", {26'd0, hwint}, 32'h10);
    tick(1);
    check("level_hw_fall", {26'd0, hwint}, 32'h00);

    // Simultaneous set and W1C
    src = 6'h04;
    wr(32'h0, 32'h04);
    rd_check("set_beats_clr", 32'h0, 32'h04);
    src = 6'h00;
    wr(32'h0, 32'h04);

    // Reset mid-request, src[0] held through reset
    src = 6'h05; tick(1);
    src = 6'h00; tick(1);
    check("pre_reset_hw", {26'd0, hwint}, 32'h05);
    reset = 1'b1; src = 6'h01; tick(1);
    reset = 1'b0;
    rd_check("rst_pend", 32'h0, 32'd0);
    rd_check("rst_mask", 32'h4, 32'd0);
    check("rst_hwint", {26'd0, hwint}, 32'd0);
    check("rst_irq", {31'd0, irq_any}, 32'd0);
    tick(1);
    rd_check("relatch", 32'h0, 32'h01);
    src = 6'h00;

    // Decode
    wr(32'h10, 32'hFFFF_FFFF);
    wr(32'h8, 32'hFFFF_FFFF);
    rd_check("dec_pend", 32'h0, 32'h01);
    rd_check("dec_mask", 32'h4, 32'h00);
    rd_check("dec_outside", 32'h10, 32'd0);
    rd_check("dec_lowbits", 32'h1, 32'h01);
    tick(1);

    // Random traffic, checked every cycle by the compare process
    for (int n = 0; n < 3000; n++) begin
      int pick;
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 2) == 0) src = 6'($urandom);
      we    = ($urandom_range(0, 2) == 0);
      wdata = $urandom;
      if ($urandom_range(0, 1) == 0) wdata[5:0] = 6'(1) << $urandom_range(0, 5);
      pick = $urandom_range(0, 9);
      if (pick < 8)       addr = BASE + 32'($urandom_range(0, 15));
      else if (pick == 8) addr = BASE + 32'h10 + 32'($urandom_range(0, 3));
      else                addr = $urandom;
      tick(1);
    end
    reset = 1'b0; we = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/irq_pending_ctrl.md
# irq_pending_ctrl

Memory-mapped interrupt controller between the peripheral interrupt sources (timers, external interrupt pin) and the CP0 `HWInt[7:2]` inputs of the pipelined MIPS core. It latches rising edges or levels on up to six sources into a pending register and masks them. It drives a registered per-source request vector to CP0 and reports the highest-priority active source. The exception handler acknowledges sources through a 16-byte register window on the data bus via the bridge.

## Interface
- `BASE_ADDR`, default `32'h0000_7F30`: window base, 16-byte aligned; decode compares `addr[31:4]` only.
- `EDGE_SRC`, default `6'b000111`: per-source mode; 1 = rising-edge latched, 0 = level.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `src`  in  6  raw interrupt sources; bit 0 has the highest priority.
- `addr`  in  32  data-bus byte address from the bridge.
- `we`  in  1  write strobe; only full-word writes are decoded.
- `wdata`  in  32  write data.
- `rdata`  out  32  combinational read data for the window; 0 when `addr` is outside the window.
- `hwint`  out  6  registered `pend & mask`, wired to CP0 `HWInt[7:2]`.
- `irq_any`  out  1  registered `|(pend & mask)`.

## Operation
- State: `pend[5:0]`, `mask[5:0]`, `src_q[5:0]` (previous `src`), `hwint`, `irq_any`.
- Register map (offset from `BASE_ADDR`):
  - `0x0` PEND: read `{26'b0,pend}`; write-1-to-clear, per bit.
  - `0x4` MASK: read/write `{26'b0,mask}`; upper bits are ignored on write.
  - `0x8` ID: read-only. Value is `32'h8000_0000 | i`, where `i` is the lowest index with `pend[i]&mask[i]`. Value is 0 when no such index exists. Writes are ignored.
  - `0xC` EOI: reads 0. Any write clears `pend[i]` for the `i` currently reported by ID; no effect if ID is 0.
- Set conditions:
  - Edge source: set when `src[i] & ~src_q[i]`.
  - Level source: set whenever `src[i]` is high.
- Priority of updates on a bit: set beats clear in the same cycle. A level source held high therefore cannot be cleared; the handler must silence the device first.
- Addressing:
  - Writes with `addr[3:2]` selecting ID, or with `addr` outside the window, change no state.
  - `addr[1:0]` is ignored.
- Masking: `mask` gates only `hwint`, `irq_any` and ID; masked sources still latch into `pend`.
- Reset (next rising edge with `reset=1`): `pend=0`, `mask=0`, `src_q=0`, `hwint=0`, `irq_any=0`. Any in-progress request is dropped.
- First cycle after reset: an edge source already high is detected as an edge (`src_q` was 0).

## Timing
- Source to `pend`: `src[i]` sampled high at edge k (with `src_q[i]=0` for edge mode) gives `pend[i]=1` after edge k.
- `pend` to output: `hwint[i]` and `irq_any` are 1 after edge k+1. Total latency from the source is 2 cycles.
- MASK write at edge k: the new mask is visible on `rdata` after edge k and on `hwint` after edge k+1.
- W1C/EOI at edge k: `pend` bit is 0 after edge k; `hwint` bit is 0 after edge k+1.
- `rdata` is purely combinational from `addr` and current state; there is no read side effect.
- EOI resolution: the ID is taken from state before edge k. A higher-priority source arriving in the same cycle is not cleared.

## Test plan
- Edge latch and priority:
  - Stimulus: `mask=6'h3F`; pulse `src[3]` for 1 cycle, then `src[1]`.
  - Required: `hwint=6'b001010` two cycles after the second pulse; ID reads `32'h8000_0001`.
  - Stimulus: EOI write.
  - Required: ID reads `32'h8000_0003`.
- Masking:
  - Stimulus: `mask=0`; pulse `src[0]`.
  - Required: PEND reads 1, `hwint=0`, ID reads 0.
  - Stimulus: write MASK=1.
  - Required: `hwint=6'b000001` one cycle later.
- Level source:
  - Stimulus: hold `src[4]` high; write PEND=`6'h10`.
  - Required: `pend[4]` stays 1.
  - Stimulus: drop `src[4]`, then write PEND=`6'h10`.
  - Required: `pend[4]=0`; `hwint[4]` falls one cycle later.
- Simultaneous set and clear:
  - Stimulus: `src[2]` rising edge in the same cycle as a W1C of bit 2.
  - Required: `pend[2]=1`.
- Reset mid-request:
  - Stimulus: `pend=6'h05`, `mask=6'h3F`; assert `reset` 1 cycle.
  - Required: `pend`, `mask`, `hwint`, `irq_any` all 0 after the edge.
  - Stimulus: hold `src[0]` high through reset.
  - Required: re-latched in the first cycle after reset.
- Decode:
  - Stimulus: write `32'hFFFF_FFFF` to `BASE_ADDR+0x10` and to `BASE_ADDR+0x8`.
  - Required: no state change; `rdata=0` at `BASE_ADDR+0x10`.
